mem_stage: RTL and testbench

- Consumes the EX stage's result bundle and performs the data-memory access over a req/ack handshake.
- Registers the write-back bundle for WB.
- Drives the MEM-stage forwarding pair (address/data) back into EX's forwarding muxes.
- Stalls the upstream pipeline while an access is outstanding, and aborts accesses that are misaligned or that time out.

---
 rtl/mem_stage.sv | 236 +++++++++++++++++++++++
 tb/tb_mem_stage.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Performs data-memory accesses over a req/ack
// handshake, registers the write-back bundle and drives the MEM forwarding pair.
// Latency: non-memory and misaligned ops take 1 cycle. Memory ops take 1 cycle
// plus the number of cycles until ack, or TIMEOUT cycles if no ack arrives.
// Backpressure: mem_stall is high for every cycle in REQ, and in_valid is ignored then.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_*                         EX result bundle (valid, control, rd, alu result, store data, size)
//   mem_stall                    upstream hold while an access is outstanding
//   dmem_* (req/we/addr/wdata/wstrb out, ack/rdata in)  data-memory handshake
//   wb_* (valid/reg_write/reg_addr/data)                write-back bundle to WB
//   mempro_addr/data, load_pending                      forwarding info to EX
//   misalign_err, bus_err        one-cycle error pulses
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_control,
  input  logic [4:0]  in_reg_addr,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_write_data,
  input  logic [1:0]  in_ls,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_reg_addr,
  output logic [31:0] wb_data,
  output logic [4:0]  mempro_addr,
  output logic [31:0] mempro_data,
  output logic        load_pending,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, REQ} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;

  // Outstanding-access context
  logic [31:0] addr_q;
  logic [1:0]  ls_q;
  logic        uns_q;
  logic        load_q;
  logic        rw_q;

  // Registered outputs
  logic        req_q, we_q;
  logic [31:0] daddr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        wbv_q, wbrw_q;
  logic [4:0]  wbrd_q;
  logic [31:0] wbdata_q;
  logic [4:0]  fa_q;
  logic [31:0] fd_q;
  logic        lp_q, merr_q, berr_q;

  // Incoming bundle decode
  logic        in_load, in_store, in_mem, in_rw, in_misalign;
  logic [31:0] st_wdata_d;
  logic [3:0]  st_wstrb_d;

  // Control bits that play no part in this stage
  logic ctrl_unused;
  assign ctrl_unused = ^{in_control[7], in_control[5], in_control[1:0]};

  always_comb begin
    in_load     = in_control[2];
    // A bundle flagged as both read and write is handled as a load.
    in_store    = in_control[3] & ~in_control[2];
    in_mem      = in_control[2] | in_control[3];
    in_rw       = in_control[4] & (in_reg_addr != 5'd0);
    in_misalign = in_mem & (((in_ls == 2'b01) & in_alu_result[0]) |
                            (in_ls[1] & (in_alu_result[1:0] != 2'b00)));
    st_wdata_d  = in_write_data;
    st_wstrb_d  = 4'b1111;
    case (in_ls)
      2'b00: begin
        st_wdata_d = {4{in_write_data[7:0]}};
        st_wstrb_d = 4'b0001 << in_alu_result[1:0];
      end
      2'b01: begin
        st_wdata_d = {2{in_write_data[15:0]}};
        st_wstrb_d = 4'b0011 << in_alu_result[1:0];
      end
      default: begin
        st_wdata_d = in_write_data;
        st_wstrb_d = 4'b1111;
      end
    endcase
    if (in_load) st_wstrb_d = 4'b0000;
  end

  // Load lane extraction: shift the addressed byte/half down to bit 0.
  logic [31:0] shifted;
  logic [31:0] load_data_d;

  always_comb begin
    shifted     = dmem_rdata >> {addr_q[1:0], 3'b000};
    load_data_d = dmem_rdata;
    case (ls_q)
      2'b00:   load_data_d = uns_q ? {24'd0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data_d = uns_q ? {16'd0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data_d = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      ls_q     <= '0;
      uns_q    <= 1'b0;
      load_q   <= 1'b0;
      rw_q     <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      daddr_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wbv_q    <= 1'b0;
      wbrw_q   <= 1'b0;
      wbrd_q   <= '0;
      wbdata_q <= '0;
      fa_q     <= '0;
      fd_q     <= '0;
      lp_q     <= 1'b0;
      merr_q   <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      // Pulses and forwarding default to idle each cycle
      wbv_q  <= 1'b0;
      wbrw_q <= 1'b0;
      merr_q <= 1'b0;
      berr_q <= 1'b0;
      fa_q   <= '0;
      fd_q   <= '0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            addr_q <= in_alu_result;
            ls_q   <= in_ls;
            uns_q  <= in_control[6];
            load_q <= in_load;
            rw_q   <= in_rw;
            wbrd_q <= in_reg_addr;
            if (!in_mem) begin
              wbv_q    <= 1'b1;
              wbdata_q <= in_alu_result;
              wbrw_q   <= in_rw;
              if (in_rw) begin
                fa_q <= in_reg_addr;
                fd_q <= in_alu_result;
              end
            end else if (in_misalign) begin
              wbv_q    <= 1'b1;
              wbdata_q <= in_alu_result;
              merr_q   <= 1'b1;
            end else begin
              state_q <= REQ;
              cnt_q   <= '0;
              req_q   <= 1'b1;
              we_q    <= in_store;
              daddr_q <= {in_alu_result[31:2], 2'b00};
              wdata_q <= st_wdata_d;
              wstrb_q <= st_wstrb_d;
              lp_q    <= in_load;
              if (in_load) fa_q <= in_reg_addr;
            end
          end
        end
        REQ: begin
          // Keep advertising the pending load's rd so EX can interlock.
          if (load_q) fa_q <= wbrd_q;
          if (dmem_ack) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            lp_q    <= 1'b0;
            fa_q    <= '0;
            wbv_q   <= 1'b1;
            if (load_q) begin
              wbdata_q <= load_data_d;
              wbrw_q   <= rw_q;
            end else begin
              wbdata_q <= addr_q;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            lp_q     <= 1'b0;
            fa_q     <= '0;
            wbv_q    <= 1'b1;
            wbdata_q <= addr_q;
            berr_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_stall    = (state_q == REQ);
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = daddr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_wstrb   = wstrb_q;
  assign wb_valid     = wbv_q;
  assign wb_reg_write = wbrw_q;
  assign wb_reg_addr  = wbrd_q;
  assign wb_data      = wbdata_q;
  assign mempro_addr  = fa_q;
  assign mempro_data  = fd_q;
  assign load_pending = lp_q;
  assign misalign_err = merr_q;
  assign bus_err      = berr_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: drives mem_stage with directed and random EX bundles and ack
// patterns. A transaction-level model predicts every output, each cycle.
// Inputs change on the falling edge and outputs are sampled on the falling edge.
module tb_mem_stage;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_control;
  logic [4:0]  in_reg_addr;
  logic [31:0] in_alu_result;
  logic [31:0] in_write_data;
  logic [1:0]  in_ls;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_reg_addr;
  logic [31:0] wb_data;
  logic [4:0]  mempro_addr;
  logic [31:0] mempro_data;
  logic        load_pending;
  logic        misalign_err;
  logic        bus_err;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_control(in_control),
    .in_reg_addr(in_reg_addr), .in_alu_result(in_alu_result),
    .in_write_data(in_write_data), .in_ls(in_ls), .mem_stall(mem_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_reg_addr(wb_reg_addr), .wb_data(wb_data), .mempro_addr(mempro_addr),
    .mempro_data(mempro_data), .load_pending(load_pending),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: one outstanding access at most.
  bit          m_busy = 0;
  int          m_waited = 0;
  bit          m_load = 0;
  bit          m_uns = 0;
  bit          m_rw = 0;
  logic [1:0]  m_ls = 0;
  logic [31:0] m_alu = 0;
  logic [4:0]  m_rd = 0;

  // Model expectations for the current cycle
  logic        e_req = 0, e_we = 0, e_wbv = 0, e_wbrw = 0, e_lp = 0, e_merr = 0, e_berr = 0;
  logic [31:0] e_addr = 0, e_wdata = 0, e_wbdata = 0, e_fd = 0;
  logic [3:0]  e_wstrb = 0;
  logic [4:0]  e_wbrd = 0, e_fa = 0;
  bit          e_reset = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int size_of(input logic [1:0] ls);
    return (ls == 2'b00) ? 1 : (ls == 2'b01) ? 2 : 4;
  endfunction

  // Gather n bytes starting at byte offset off, little-endian, then extend.
  function automatic logic [31:0] load_value(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] ls, input bit uns);
    int n = size_of(ls);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < n; i++) r = r | (32'(word[8*(int'(off)+i) +: 8]) << (8*i));
    if (!uns && n < 4 && r[8*n-1]) r = r | (32'hFFFF_FFFF << (8*n));
    return r;
  endfunction

  task automatic model_step();
    int n;
    bit mem;
    e_wbv = 0; e_wbrw = 0; e_merr = 0; e_berr = 0; e_reset = 0;
    if (rst) begin
      m_busy = 0; e_reset = 1;
      e_we = 0; e_addr = 0; e_wdata = 0; e_wstrb = 0; e_wbrd = 0; e_wbdata = 0;
    end else if (m_busy) begin
      if (dmem_ack) begin
        m_busy = 0; e_wbv = 1; e_wbrd = m_rd;
        if (m_load) begin
          e_wbdata = load_value(dmem_rdata, m_alu[1:0], m_ls, m_uns);
          e_wbrw = m_rw;
        end
      end else if (m_waited == TO - 1) begin
        m_busy = 0; e_wbv = 1; e_berr = 1; e_wbrd = m_rd;
      end else begin
        m_waited++;
      end
    end else if (in_valid) begin
      n = size_of(in_ls);
      mem = in_control[2] | in_control[3];
      m_rd = in_reg_addr; m_alu = in_alu_result; m_ls = in_ls;
      m_load = in_control[2]; m_uns = in_control[6];
      m_rw = in_control[4] && (in_reg_addr != 0);
      if (!mem) begin
        e_wbv = 1; e_wbrd = m_rd; e_wbdata = m_alu; e_wbrw = m_rw;
      end else if ((m_alu % n) != 0) begin
        e_wbv = 1; e_merr = 1; e_wbrd = m_rd;
      end else begin
        m_busy = 1; m_waited = 0;
        e_addr = m_alu - (m_alu % 4);
        e_we = !m_load;
        for (int i = 0; i < 4; i++) begin
          e_wstrb[i] = !m_load && (i >= int'(m_alu[1:0])) && (i < int'(m_alu[1:0]) + n);
          e_wdata[8*i +: 8] = in_write_data[8*(i % n) +: 8];
        end
      end
    end
    e_req = m_busy;
    e_lp = m_busy && m_load;
    e_fa = 0; e_fd = 0;
    if (e_lp) e_fa = m_rd;
    else if (e_wbv && e_wbrw && !m_load) begin e_fa = e_wbrd; e_fd = e_wbdata; end
  endtask

  task automatic check_all();
    check("mem_stall", 32'(mem_stall), 32'(m_busy));
    check("dmem_req", 32'(dmem_req), 32'(e_req));
    if (e_req || e_reset) begin
      check("dmem_addr", dmem_addr, e_addr);
      check("dmem_we", 32'(dmem_we), 32'(e_we));
      check("dmem_wstrb", 32'(dmem_wstrb), 32'(e_wstrb));
      if (e_we || e_reset) check("dmem_wdata", dmem_wdata, e_wdata);
    end
    check("wb_valid", 32'(wb_valid), 32'(e_wbv));
    check("wb_reg_write", 32'(wb_reg_write), 32'(e_wbrw));
    check("misalign_err", 32'(misalign_err), 32'(e_merr));
    check("bus_err", 32'(bus_err), 32'(e_berr));
    check("mempro_addr", 32'(mempro_addr), 32'(e_fa));
    check("mempro_data", mempro_data, e_fd);
    check("load_pending", 32'(load_pending), 32'(e_lp));
    if (e_wbv || e_reset) check("wb_reg_addr", 32'(wb_reg_addr), 32'(e_wbrd));
    if (e_wbrw || e_reset) check("wb_data", wb_data, e_wbdata);
  endtask

  // Inputs are already set; advance one edge, update model, compare.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_op(input logic [7:0] ctrl, input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [1:0] ls);
    in_valid = 1; in_control = ctrl; in_reg_addr = rd;
    in_alu_result = alu; in_write_data = wd; in_ls = ls;
  endtask

  initial begin
    int stalls;
    int reqs;
    int quiet;
    int kind;
    logic [7:0] ctrl;

    rst = 1; in_valid = 0; in_control = 0; in_reg_addr = 0; in_alu_result = 0;
    in_write_data = 0; in_ls = 0; dmem_ack = 0; dmem_rdata = 0;
    cycle(); cycle();
    check("reset wb_valid", 32'(wb_valid), 32'd0);
    check("reset dmem_req", 32'(dmem_req), 32'd0);
    check("reset wb_data", wb_data, 32'd0);
    rst = 0;

    // ALU op: rd=5, reg_write
    set_op(8'h10, 5'd5, 32'h0000_0123, 32'h0, 2'b10);
    cycle(); in_valid = 0;
    check("alu wb_valid", 32'(wb_valid), 32'd1);
    check("alu wb_data", wb_data, 32'h0000_0123);
    check("alu mempro_addr", 32'(mempro_addr), 32'd5);
    check("alu mempro_data", mempro_data, 32'h0000_0123);
    check("alu no req", 32'(dmem_req), 32'd0);

    // lb at 0x1003, ack on the third REQ cycle
    set_op(8'h14, 5'd7, 32'h0000_1003, 32'h0, 2'b00);
    dmem_rdata = 32'h80AB_CDEF;
    cycle(); in_valid = 0;
    check("lb dmem_addr", dmem_addr, 32'h0000_1000);
    check("lb load_pending", 32'(load_pending), 32'd1);
    check("lb mempro_addr", 32'(mempro_addr), 32'd7);
    stalls = 0;
    for (int k = 0; k < 3; k++) begin
      if (mem_stall) stalls++;
      dmem_ack = (k == 2);
      cycle();
    end
    dmem_ack = 0;
    check("lb stall cycles", 32'(stalls), 32'd3);
    check("lb stall released", 32'(mem_stall), 32'd0);
    check("lb wb_data", wb_data, 32'hFFFF_FF80);

    // lhu at 0x1002, immediate ack
    set_op(8'h54, 5'd8, 32'h0000_1002, 32'h0, 2'b01);
    cycle(); in_valid = 0; dmem_ack = 1;
    cycle(); dmem_ack = 0;
    check("lhu wb_data", wb_data, 32'h0000_80AB);

    // sh of 0x1234_BEEF to 0x2002
    set_op(8'h18, 5'd3, 32'h0000_2002, 32'h1234_BEEF, 2'b01);
    cycle(); in_valid = 0;
    check("sh wdata", dmem_wdata, 32'hBEEF_BEEF);
    check("sh wstrb", 32'(dmem_wstrb), 32'hC);
    check("sh we", 32'(dmem_we), 32'd1);
    dmem_ack = 1;
    cycle(); dmem_ack = 0;
    check("sh wb_reg_write", 32'(wb_reg_write), 32'd0);

    // misaligned lw at 0x3001
    set_op(8'h14, 5'd4, 32'h0000_3001, 32'h0, 2'b10);
    cycle(); in_valid = 0;
    check("misalign pulse", 32'(misalign_err), 32'd1);
    check("misalign no req", 32'(dmem_req), 32'd0);
    check("misalign wb_reg_write", 32'(wb_reg_write), 32'd0);
    cycle();
    check("misalign pulse end", 32'(misalign_err), 32'd0);

    // lw with no ack: timeout
    set_op(8'h14, 5'd6, 32'h0000_4000, 32'h0, 2'b10);
    cycle(); in_valid = 0;
    reqs = 0;
    for (int k = 0; k < 40 && dmem_req; k++) begin
      reqs++;
      cycle();
    end
    check("timeout req cycles", 32'(reqs), 32'd16);
    check("timeout bus_err", 32'(bus_err), 32'd1);
    check("timeout stall", 32'(mem_stall), 32'd0);

    // reset in REQ, stray ack afterwards
    set_op(8'h14, 5'd9, 32'h0000_5000, 32'h0, 2'b10);
    cycle(); in_valid = 0;
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    cycle();
    dmem_ack = 1;
    cycle(); dmem_ack = 0;
    check("rst stray wb_valid", 32'(wb_valid), 32'd0);
    check("rst stray req", 32'(dmem_req), 32'd0);
    check("rst stray stall", 32'(mem_stall), 32'd0);
    check("rst stray wb_data", wb_data, 32'd0);
    set_op(8'h10, 5'd9, 32'h0000_0ABC, 32'h0, 2'b10);
    cycle(); in_valid = 0;
    check("post-rst wb_data", wb_data, 32'h0000_0ABC);
    check("post-rst wb_valid", 32'(wb_valid), 32'd1);

    // random traffic
    quiet = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (quiet > 0) quiet--;
      else if ($urandom_range(0, 149) == 0) quiet = 30;
      dmem_ack = (quiet == 0) && ($urandom_range(0, 2) == 0);
      dmem_rdata = $urandom;
      kind = $urandom_range(0, 2);
      ctrl = 8'($urandom);
      ctrl[2] = (kind == 1);
      ctrl[3] = (kind == 2) || (ctrl[3] && kind == 1);
      set_op(ctrl, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
             {$urandom_range(0, 1) ? 30'($urandom) : 30'd0, 2'($urandom)},
             $urandom, 2'($urandom));
      in_valid = $urandom_range(0, 1) == 1;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
